// File: rtl/frame_echo_pkg.sv
// Shared types and helpers for the frame echo buffer.
package frame_echo_pkg;

    typedef enum logic [1:0] {
        RECV = 2'd0,
        SEND = 2'd1,
        TERM = 2'd2,
        CHK  = 2'd3
    } state_t;

    // Width needed to hold a count in the range 0..depth.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/echo_mem.sv
// Frame storage: synchronous write, combinational read, no reset.
module echo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int AW     = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/frame_echo_buffer.sv
// Store-and-echo engine: buffers a terminated frame, replays it, then emits the terminator.
// Optional XOR checksum beat before the terminator when FRAME_ECHO_CHECKSUM_EN is defined.
module frame_echo_buffer
    import frame_echo_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                DEPTH    = 256,
    parameter logic [DATA_W-1:0] EOF_WORD = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    output logic                      out_valid,
    input  logic                      out_ack,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_last,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      overflow,
    output logic                      busy,
    output logic [1:0]                dbg_state
);

    // Input side: a word transfers when in_valid && in_ready at a rising edge.
    // Output side: a beat transfers when out_valid && out_ack; out_data/out_last hold until then.

    localparam int CW = cnt_w(DEPTH);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    localparam logic [1:0] ST_RECV = RECV;
    localparam logic [1:0] ST_SEND = SEND;
    localparam logic [1:0] ST_TERM = TERM;
`ifdef FRAME_ECHO_CHECKSUM_EN
    localparam logic [1:0] ST_CHK        = CHK;
    localparam logic [1:0] ST_AFTER_DATA = ST_CHK;
`else
    localparam logic [1:0] ST_AFTER_DATA = ST_TERM;
`endif

    logic [1:0]        state;
    logic [CW-1:0]     rd_idx;
    logic [DATA_W-1:0] rd_data;
    logic              in_fire;
    logic              is_eof;
    logic              store;

    assign in_ready  = (state == ST_RECV);
    assign in_fire   = in_ready && in_valid;
    assign is_eof    = (in_data == EOF_WORD);
    assign store     = in_fire && !is_eof && (count < DEPTH_C);
    assign out_valid = (state != ST_RECV);
    assign out_last  = (state == ST_TERM);
    assign busy      = (state != ST_RECV);
    assign dbg_state = state;

    echo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (store),
        .wr_addr (count[AW-1:0]),
        .wr_data (in_data),
        .rd_addr (rd_idx[AW-1:0]),
        .rd_data (rd_data)
    );

`ifdef FRAME_ECHO_CHECKSUM_EN
    logic [DATA_W-1:0] chk_acc;

    // Only stored words contribute; dropped overflow words never reach the accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_acc <= '0;
        end else if (state == ST_TERM && out_ack) begin
            chk_acc <= '0;
        end else if (store) begin
            chk_acc <= chk_acc ^ in_data;
        end
    end
`endif

    always_comb begin
        out_data = rd_data;
        case (state)
            ST_TERM: out_data = EOF_WORD;
`ifdef FRAME_ECHO_CHECKSUM_EN
            ST_CHK:  out_data = chk_acc;
`endif
            default: out_data = rd_data;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RECV;
            count    <= '0;
            rd_idx   <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                ST_RECV: begin
                    if (in_fire) begin
                        if (is_eof) begin
                            rd_idx <= '0;
                            state  <= (count == '0) ? ST_AFTER_DATA : ST_SEND;
                        end else if (store) begin
                            count <= count + ONE_C;
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    if (out_ack) begin
                        rd_idx <= rd_idx + ONE_C;
                        if (rd_idx == count - ONE_C) begin
                            state <= ST_AFTER_DATA;
                        end
                    end
                end
                ST_TERM: begin
                    if (out_ack) begin
                        count <= '0;
                        state <= ST_RECV;
                    end
                end
                default: begin
                    // Checksum beat: terminator follows once it is taken.
                    if (out_ack) begin
                        state <= ST_TERM;
                    end
                end
            endcase
        end
    end

endmodule
